regfile_scan_checker: RTL and testbench

Synthesizable run-and-check harness sitting between the processor, its register file and an expected-value ROM. It lets the processor run for a programmed number of cycles and logs every register write into a trace FIFO. It then takes over register-file read port A to scan all registers against expected values, giving on-chip pass/fail and an error count without a simulator.

---
 rtl/regfile_scan_checker_pkg.sv | 12 +
 rtl/regfile_scan_checker_trace_fifo.sv | 40 ++++
 rtl/regfile_scan_checker.sv | 95 +++++++++
 tb/tb_regfile_scan_checker.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_scan_checker_pkg.sv
// regfile_scan_checker_pkg: FSM encoding and trace-entry layout shared by the checker
package regfile_scan_checker_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SCAN = 2'd2,
    ST_DONE = 2'd3
  } state_t;
  function automatic int entry_w(input int cyc_w, input int reg_aw, input int data_w);
    return cyc_w + reg_aw + data_w;
  endfunction
endpackage

// File: rtl/regfile_scan_checker_trace_fifo.sv
// regfile_scan_checker_trace_fifo: sync FIFO with sticky overflow, extra pointer bit for occupancy
module regfile_scan_checker_trace_fifo #(
  parameter int W      = 53,
  parameter int LOG_AW = 6
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] dout,
  output logic         overflow
);
  logic [W-1:0] mem [2**LOG_AW];
  logic [LOG_AW:0] wp, rp;
  logic full, pop_ok, push_ok;
  assign valid = wp != rp;
  assign full = (wp ^ rp) == {1'b1, {LOG_AW{1'b0}}};
  assign pop_ok = pop && valid;
  assign push_ok = push && (!full || pop_ok);
  assign dout = valid ? mem[rp[LOG_AW-1:0]] : '0;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      wp <= '0;
      rp <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      wp <= '0;
      rp <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wp <= wp + (LOG_AW+1)'(1);
      if (pop_ok) rp <= rp + (LOG_AW+1)'(1);
      if (push && !push_ok) overflow <= 1'b1;
    end
  always_ff @(posedge clock)
    if (push_ok && !clr) mem[wp[LOG_AW-1:0]] <= din;
endmodule

// File: rtl/regfile_scan_checker.sv
// regfile_scan_checker: runs the core for N cycles logging writes, then scans the regfile against a ROM
module regfile_scan_checker
  import regfile_scan_checker_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5,
  parameter int CYC_W    = 16,
  parameter int LOG_AW   = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [CYC_W-1:0]  num_cycles,
  input  logic              rwe,
  input  logic [REG_AW-1:0] rd,
  input  logic [DATA_W-1:0] rData,
  output logic              test_mode,
  output logic [REG_AW-1:0] test_reg,
  input  logic [DATA_W-1:0] regA,
  output logic [REG_AW-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  output logic              log_valid,
  input  logic              log_ready,
  output logic [CYC_W-1:0]  log_cycle,
  output logic [REG_AW-1:0] log_reg,
  output logic [DATA_W-1:0] log_data,
  output logic              log_overflow,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [REG_AW:0]   err_count,
  output logic [REG_AW-1:0] first_err_reg
);
  localparam int EW = entry_w(CYC_W, REG_AW, DATA_W);
  state_t state, nxt;
  logic [CYC_W-1:0] cyc, ncyc;
  logic [REG_AW:0] scnt;
  logic [DATA_W-1:0] a_q;
  logic [EW-1:0] head;
  logic accept, cmp_en, mism;
  assign accept = start && (state == ST_IDLE || state == ST_DONE);
  // scnt==0 only issues address 0; compares trail the address by one cycle
  assign cmp_en = state == ST_SCAN && scnt != '0;
  assign mism = cmp_en && a_q != exp_data;
  always_comb begin
    nxt = state;
    if (accept) nxt = num_cycles == '0 ? ST_SCAN : ST_RUN;
    else if (state == ST_RUN && cyc == ncyc - CYC_W'(1)) nxt = ST_SCAN;
    else if (state == ST_SCAN && scnt == (REG_AW+1)'(NUM_REGS)) nxt = ST_DONE;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= ST_IDLE;
      cyc <= '0;
      ncyc <= '0;
      scnt <= '0;
      a_q <= '0;
      err_count <= '0;
      first_err_reg <= '0;
    end else begin
      state <= nxt;
      a_q <= regA;
      if (accept) begin
        cyc <= '0;
        ncyc <= num_cycles;
        scnt <= '0;
        err_count <= '0;
        first_err_reg <= '0;
      end else begin
        if (state == ST_RUN) cyc <= cyc + CYC_W'(1);
        if (state == ST_SCAN) scnt <= scnt + (REG_AW+1)'(1);
        if (mism) err_count <= err_count + (REG_AW+1)'(1);
        if (mism && err_count == '0) first_err_reg <= REG_AW'(scnt - (REG_AW+1)'(1));
      end
    end
  assign test_mode = state == ST_SCAN;
  assign test_reg = test_mode ? scnt[REG_AW-1:0] : '0;
  assign exp_addr = test_reg;
  assign busy = state == ST_RUN || state == ST_SCAN;
  assign done = state == ST_DONE;
  assign pass = done && err_count == '0;
  assign {log_cycle, log_reg, log_data} = head;
  regfile_scan_checker_trace_fifo #(.W(EW), .LOG_AW(LOG_AW)) trace_fifo (
    .clock    (clock),
    .reset    (reset),
    .clr      (accept),
    .push     (state == ST_RUN && rwe && rd != '0),
    .din      ({cyc, rd, rData}),
    .pop      (log_ready),
    .valid    (log_valid),
    .dout     (head),
    .overflow (log_overflow)
  );
endmodule

// File: tb/tb_regfile_scan_checker.sv
// tb_regfile_scan_checker: random and directed runs against a queue/array model of regfile, ROM and trace
module tb_regfile_scan_checker;
  localparam int DW = 32, NR = 32, AW = 5, CW = 16, LW = 2, DEPTH = 4;
  logic clock = 0, reset = 0, start = 0, rwe = 0, log_ready = 0;
  logic [CW-1:0] num_cycles = '0;
  logic [AW-1:0] rd = '0;
  logic [DW-1:0] rData = '0, exp_data = '0;
  logic [DW-1:0] regA;
  logic test_mode, log_valid, log_overflow, busy, done, pass;
  logic [AW-1:0] test_reg, exp_addr, log_reg, first_err_reg;
  logic [CW-1:0] log_cycle;
  logic [DW-1:0] log_data;
  logic [AW:0] err_count;
  logic [DW-1:0] rf [NR];
  logic [DW-1:0] rom [NR];
  typedef struct packed {
    logic [CW-1:0] c;
    logic [AW-1:0] r;
    logic [DW-1:0] d;
  } ent_t;
  ent_t mq[$];
  bit movf;
  int ph, cur_cyc, n_chk, n_fail;
  bit p_en [64], p_rdy [64], p_st [64];
  logic [AW-1:0] p_rd [64];
  logic [DW-1:0] p_dat [64];
  always #5 clock = ~clock;
  assign regA = rf[test_reg];
  always @(posedge clock) exp_data <= rom[exp_addr];
  regfile_scan_checker #(.DATA_W(DW), .NUM_REGS(NR), .REG_AW(AW), .CYC_W(CW), .LOG_AW(LW)) dut (
    .clock(clock), .reset(reset), .start(start), .num_cycles(num_cycles),
    .rwe(rwe), .rd(rd), .rData(rData), .test_mode(test_mode), .test_reg(test_reg),
    .regA(regA), .exp_addr(exp_addr), .exp_data(exp_data), .log_valid(log_valid),
    .log_ready(log_ready), .log_cycle(log_cycle), .log_reg(log_reg), .log_data(log_data),
    .log_overflow(log_overflow), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_reg(first_err_reg)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, 64'({test_mode, test_reg, exp_addr, log_valid, log_overflow,
                              busy, done, pass, err_count, first_err_reg}), 64'(0));
    check({tag, "_log"}, 64'({log_cycle, log_reg, log_data}), 64'(0));
  endtask
  // one clock: sample at negedge against the model, then apply the coming edge to the model
  task automatic cycle();
    bit pop, full;
    ent_t e;
    @(negedge clock);
    check("busy", 64'(busy), 64'(ph == 1 || ph == 2));
    check("test_mode", 64'(test_mode), 64'(ph == 2));
    check("done", 64'(done), 64'(ph == 3));
    check("log_valid", 64'(log_valid), 64'(mq.size() != 0));
    check("log_overflow", 64'(log_overflow), 64'(movf));
    if (mq.size() != 0) check("log_head", 64'({log_cycle, log_reg, log_data}), 64'(mq[0]));
    pop = log_ready && mq.size() != 0;
    if (start && (ph == 0 || ph == 3)) begin
      mq.delete();
      movf = 0;
    end else begin
      full = mq.size() == DEPTH;
      if (pop) void'(mq.pop_front());
      if (ph == 1 && rwe && rd != 0) begin
        e.c = CW'(cur_cyc);
        e.r = rd;
        e.d = rData;
        if (!full || pop) mq.push_back(e);
        else movf = 1;
      end
    end
    if (rwe && rd != 0) rf[rd] = rData;
    @(posedge clock);
    #1;
  endtask
  task automatic clear_plan();
    for (int j = 0; j < 64; j++) begin
      p_en[j] = 0; p_rdy[j] = 0; p_st[j] = 0; p_rd[j] = '0; p_dat[j] = '0;
    end
  endtask
  task automatic rand_plan(input int n);
    for (int j = 0; j < n; j++) begin
      p_en[j] = 1'($urandom_range(0, 1));
      p_rd[j] = AW'($urandom_range(0, NR-1));
      p_dat[j] = $urandom;
      p_rdy[j] = 1'($urandom_range(0, 1));
      p_st[j] = $urandom_range(0, 9) == 0;
    end
  endtask
  // ROM = regfile contents after the planned writes, with some entries corrupted
  task automatic build_rom(input int n, input int nflip);
    logic [DW-1:0] t [NR];
    t = rf;
    for (int j = 0; j < n; j++) if (p_en[j] && p_rd[j] != 0) t[p_rd[j]] = p_dat[j];
    rom = t;
    for (int k = 0; k < nflip; k++) rom[$urandom_range(0, NR-1)] ^= DW'(1) << $urandom_range(0, DW-1);
  endtask
  task automatic run(input int n, input int abort_k);
    int errs, first;
    log_ready = 0;
    start = 1;
    num_cycles = CW'(n);
    cycle();
    start = 0;
    num_cycles = CW'($urandom);
    check("err_cleared", 64'(err_count), 64'(0));
    ph = n == 0 ? 2 : 1;
    for (int j = 0; j < n; j++) begin
      rwe = p_en[j]; rd = p_rd[j]; rData = p_dat[j]; log_ready = p_rdy[j];
      start = p_st[j]; cur_cyc = j;
      cycle();
    end
    rwe = 0; log_ready = 0; start = 0; ph = 2;
    for (int k = 0; k <= NR; k++) begin
      if (k == abort_k) begin
        @(negedge clock);
        check("scan_idx", 64'(test_reg), 64'(k));
        reset = 0;
        #1;
        check_zero("async_reset");
        @(posedge clock);
        #1;
        check_zero("held_reset");
        @(negedge clock);
        reset = 1;
        @(posedge clock);
        #1;
        mq.delete();
        movf = 0;
        ph = 0;
        return;
      end
      cycle();
    end
    ph = 3;
    errs = 0;
    first = 0;
    for (int i = NR-1; i >= 0; i--) if (rf[i] !== rom[i]) begin errs++; first = i; end
    @(negedge clock);
    check("done_end", 64'(done), 64'(1));
    check("err_count", 64'(err_count), 64'(errs));
    check("first_err_reg", 64'(first_err_reg), 64'(first));
    check("pass", 64'(pass), 64'(errs == 0));
    @(posedge clock);
    #1;
    log_ready = 1;
    for (int i = 0; i <= DEPTH; i++) cycle();
    log_ready = 0;
  endtask
  initial begin
    for (int i = 0; i < NR; i++) begin
      rf[i] = i == 0 ? '0 : $urandom;
      rom[i] = '0;
    end
    ph = 0;
    movf = 0;
    #12;
    check_zero("por");
    @(negedge clock);
    reset = 1;
    @(posedge clock);
    #1;
    clear_plan();
    p_en[2] = 1; p_rd[2] = 3; p_dat[2] = 5;
    p_en[9] = 1; p_rd[9] = 7; p_dat[9] = '1;
    build_rom(10, 0);
    run(10, -1);
    check("t1_pass", 64'(pass), 64'(1));
    clear_plan();
    p_en[0] = 1; p_rd[0] = 4; p_dat[0] = 8;
    p_en[1] = 1; p_rd[1] = 20; p_dat[1] = 32'h1234;
    build_rom(4, 0);
    rom[4] = 9;
    rom[20] = 32'h1235;
    run(4, -1);
    check("t2_err", 64'(err_count), 64'(2));
    check("t2_first", 64'(first_err_reg), 64'(4));
    check("t2_pass", 64'(pass), 64'(0));
    clear_plan();
    for (int j = 0; j < 6; j++) begin
      p_en[j] = 1; p_rd[j] = AW'(j + 1); p_dat[j] = DW'(100 + j);
    end
    p_en[6] = 1; p_rd[6] = 9; p_dat[6] = 32'hABCD; p_rdy[6] = 1;
    build_rom(8, 0);
    run(8, -1);
    check("t3_overflow", 64'(log_overflow), 64'(1));
    clear_plan();
    p_en[1] = 1; p_rd[1] = 0; p_dat[1] = 32'hDEAD;
    p_en[4] = 1; p_rd[4] = 0; p_dat[4] = 32'hBEEF;
    p_rd[2] = 5; p_dat[2] = 32'h55;
    build_rom(6, 0);
    run(6, -1);
    check("t4_no_log", 64'(log_valid), 64'(0));
    build_rom(0, 1);
    run(0, -1);
    clear_plan();
    rand_plan(5);
    for (int j = 0; j < 5; j++) p_st[j] = 0;
    build_rom(5, 2);
    run(5, 12);
    run(5, -1);
    clear_plan();
    p_st[3] = 1;
    p_en[5] = 1; p_rd[5] = 11; p_dat[5] = 32'h77;
    build_rom(8, 0);
    run(8, -1);
    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(1, 20);
      clear_plan();
      rand_plan(n);
      build_rom(n, $urandom_range(0, 3));
      run(n, -1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
